// File: rtl/dpsram_bw.sv
// dpsram_bw: true dual-port SRAM with byte write enables and a power-up
// clear sweep.
//
// After rst_n releases, the FSM spends DEPTH cycles in INIT writing zero to
// every word (init_busy=1, port accesses ignored). It then moves to READY,
// where both ports accept one access per cycle with no stalls.
//   - Reads are read-before-write: a read of a word written in the same cycle
//     returns the old contents.
//   - When both ports write the same word, port A owns the overlapping bytes.
//   - An overlapping same-address dual write pulses coll and bumps the
//     saturating coll_cnt.
//
// Optional feature: define DPSRAM_OUT_REG_EN to add an output register
// stage. Read latency then becomes 2 cycles instead of 1; collision
// reporting is unaffected.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cs_x, we_x            chip select, 1=write 0=read          (x = a, b)
//   be_x [WIDTH/8]        byte write enables
//   ad_x [DEPTH_LOG]      word address
//   wd_x [WIDTH]          write data
//   rd_x [WIDTH]          read data, held between reads
//   rvalid_x              one-cycle pulse marking fresh rd_x
//   init_busy             high while the clear sweep runs
//   coll                  one-cycle pulse on a byte-overlapping dual write
//   coll_cnt [8]          saturating collision count
module dpsram_bw #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 32,
   parameter int DEPTH_LOG = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cs_a,
   input  logic                 we_a,
   input  logic [WIDTH/8-1:0]   be_a,
   input  logic [DEPTH_LOG-1:0] ad_a,
   input  logic [WIDTH-1:0]     wd_a,
   output logic [WIDTH-1:0]     rd_a,
   output logic                 rvalid_a,
   input  logic                 cs_b,
   input  logic                 we_b,
   input  logic [WIDTH/8-1:0]   be_b,
   input  logic [DEPTH_LOG-1:0] ad_b,
   input  logic [WIDTH-1:0]     wd_b,
   output logic [WIDTH-1:0]     rd_b,
   output logic                 rvalid_b,
   output logic                 init_busy,
   output logic                 coll,
   output logic [7:0]           coll_cnt
);

   localparam int NB = WIDTH / 8;

   typedef enum logic {INIT, READY} state_t;

   state_t               state, state_nx;
   logic [DEPTH_LOG-1:0] ptr, ptr_nx;
   logic                 clr_en;

   logic [WIDTH-1:0] mem [DEPTH];

   logic wr_a, wr_b, re_a, re_b, coll_hit;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      clr_en   = 1'b0;
      case (state)
         INIT: begin
            clr_en = 1'b1;
            if (ptr == DEPTH_LOG'(DEPTH - 1)) begin
               state_nx = READY;
               ptr_nx   = '0;
            end else begin
               ptr_nx = ptr + 1'b1;
            end
         end
         READY: ;
         default: state_nx = INIT;
      endcase
   end

   assign init_busy = (state == INIT);

   assign wr_a     = (state == READY) && cs_a && we_a;
   assign wr_b     = (state == READY) && cs_b && we_b;
   assign re_a     = (state == READY) && cs_a && !we_a;
   assign re_b     = (state == READY) && cs_b && !we_b;
   assign coll_hit = wr_a && wr_b && (ad_a == ad_b) && (|(be_a & be_b));

   // Memory array (no reset; contents are cleared by the INIT sweep).
   // Port B bytes are scheduled first so that the later port A assignment
   // wins on overlapping bytes of the same word.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[ptr] <= '0;
      end else begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (wr_b && be_b[i]) mem[ad_b][i*8 +: 8] <= wd_b[i*8 +: 8];
            if (wr_a && be_a[i]) mem[ad_a][i*8 +: 8] <= wd_a[i*8 +: 8];
         end
      end
   end

   // First read stage: capture pre-write contents (read-before-write).
   logic [WIDTH-1:0] rq_a, rq_b;
   logic             rv_a, rv_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq_a <= '0;
         rq_b <= '0;
         rv_a <= 1'b0;
         rv_b <= 1'b0;
      end else begin
         rv_a <= re_a;
         rv_b <= re_b;
         if (re_a) rq_a <= mem[ad_a];
         if (re_b) rq_b <= mem[ad_b];
      end
   end

`ifdef DPSRAM_OUT_REG_EN
   // Second stage only loads on a completing read so rd holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_a     <= '0;
         rd_b     <= '0;
         rvalid_a <= 1'b0;
         rvalid_b <= 1'b0;
      end else begin
         rvalid_a <= rv_a;
         rvalid_b <= rv_b;
         if (rv_a) rd_a <= rq_a;
         if (rv_b) rd_b <= rq_b;
      end
   end
`else
   assign rd_a     = rq_a;
   assign rd_b     = rq_b;
   assign rvalid_a = rv_a;
   assign rvalid_b = rv_b;
`endif

   // Collision reporting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coll     <= 1'b0;
         coll_cnt <= '0;
      end else begin
         coll <= coll_hit;
         if (coll_hit && (coll_cnt != 8'hFF)) coll_cnt <= coll_cnt + 8'd1;
      end
   end

endmodule
